// File: rtl/pause_frame_gen.sv
// Purpose : builds a minimum-length 802.3x PAUSE/XON frame byte stream on request.
// Latency : first byte valid one enabled cycle after pause_req is captured in IDLE.
// Backpressure: a byte advances only when tx_valid & tx_ready & clk_en; otherwise all outputs hold.
//
// Ports:
//   clk, rstn        - single clock, asynchronous active-low reset
//   clk_en           - clock enable; every register advances only when high
//   pause_req        - level request for one PAUSE frame (sampled in IDLE only)
//   pause_quanta     - pause time for the frame, 0 = XON
//   mac_sa           - station source address, [47:40] sent first
//   tx_ready         - downstream accepts the current byte
//   tx_data/tx_valid - byte stream, tx_sof/tx_eof mark first/last byte
//   pause_ack        - single-cycle pulse in the DONE state after the last byte
//   busy             - high whenever the FSM is not IDLE
module pause_frame_gen #(
    parameter int MIN_LEN = 60
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clk_en,
    input  logic        pause_req,
    input  logic [15:0] pause_quanta,
    input  logic [47:0] mac_sa,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        pause_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(MIN_LEN - 1);

    state_t      state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [15:0] quanta_q, quanta_d;
    logic [47:0] sa_q,     sa_d;
    logic [7:0]  data_q,   data_d;
    logic        valid_q,  valid_d;
    logic        sof_q,    sof_d;
    logic        eof_q,    eof_d;
    logic        ack_q,    ack_d;
    logic        busy_q,   busy_d;

    // Frame content indexed by byte position; positions past the control
    // fields are zero padding up to MIN_LEN.
    function automatic logic [7:0] frame_byte(input logic [5:0]  idx,
                                              input logic [15:0] q,
                                              input logic [47:0] sa);
        logic [7:0] b;
        case (idx)
            6'd0:    b = 8'h01;
            6'd1:    b = 8'h80;
            6'd2:    b = 8'hC2;
            6'd3:    b = 8'h00;
            6'd4:    b = 8'h00;
            6'd5:    b = 8'h01;
            6'd6:    b = sa[47:40];
            6'd7:    b = sa[39:32];
            6'd8:    b = sa[31:24];
            6'd9:    b = sa[23:16];
            6'd10:   b = sa[15:8];
            6'd11:   b = sa[7:0];
            6'd12:   b = 8'h88;
            6'd13:   b = 8'h08;
            6'd14:   b = 8'h00;
            6'd15:   b = 8'h01;
            6'd16:   b = q[15:8];
            6'd17:   b = q[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quanta_d = quanta_q;
        sa_d     = sa_q;
        case (state_q)
            ST_IDLE: begin
                if (pause_req) begin
                    quanta_d = pause_quanta;
                    sa_d     = mac_sa;
                    cnt_d    = 6'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (valid_q && tx_ready) begin
                    // >= guards against a count that somehow overshot.
                    if (cnt_q >= LAST_IDX) begin
                        cnt_d   = 6'd0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        // Outputs are registered: derive them from the next state so they
        // line up with the state they describe.
        valid_d = (state_d == ST_SEND);
        sof_d   = valid_d && (cnt_d == 6'd0);
        eof_d   = valid_d && (cnt_d == LAST_IDX);
        data_d  = valid_d ? frame_byte(cnt_d, quanta_d, sa_d) : 8'h00;
        ack_d   = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            quanta_q <= 16'h0000;
            sa_q     <= 48'h0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quanta_q <= quanta_d;
            sa_q     <= sa_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign tx_sof    = sof_q;
    assign tx_eof    = eof_q;
    assign pause_ack = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pause_frame_gen.sv
module tb_pause_frame_gen;

    localparam int FLEN = 60;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        clk_en = 1'b1;
    logic        pause_req = 1'b0;
    logic [15:0] pause_quanta = 16'h0;
    logic [47:0] mac_sa = 48'h0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sof;
    logic        tx_eof;
    logic        pause_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pause_frame_gen #(.MIN_LEN(FLEN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clk_en       (clk_en),
        .pause_req    (pause_req),
        .pause_quanta (pause_quanta),
        .mac_sa       (mac_sa),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_sof       (tx_sof),
        .tx_eof       (tx_eof),
        .pause_ack    (pause_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected PAUSE frame bytes, written out from the frame layout.
    function automatic logic [7:0] exp_byte(input int i, input logic [15:0] q, input logic [47:0] sa);
        case (i)
            0:  return 8'h01;
            1:  return 8'h80;
            2:  return 8'hC2;
            3:  return 8'h00;
            4:  return 8'h00;
            5:  return 8'h01;
            6:  return sa[47:40];
            7:  return sa[39:32];
            8:  return sa[31:24];
            9:  return sa[23:16];
            10: return sa[15:8];
            11: return sa[7:0];
            12: return 8'h88;
            13: return 8'h08;
            14: return 8'h00;
            15: return 8'h01;
            16: return q[15:8];
            17: return q[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, tx_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ack"}, pause_ack, 1'b0);
        chk({tag, "_sof"}, tx_sof, 1'b0);
        chk({tag, "_eof"}, tx_eof, 1'b0);
        chk({tag, "_data"}, tx_data, 8'h00);
    endtask

    // Entered at the sample point where byte 0 should be on the bus.
    // Returns at the sample point of the DONE cycle.
    task automatic check_frame(input logic [15:0] q, input logic [47:0] sa, input bit toggle,
                               input bit chg, input logic [15:0] new_q, input bit stall);
        int  idx = 0;
        int  cyc = 0;
        int  stall_cnt = 0;
        bit  rdy;
        bit  en;
        while (idx < FLEN && cyc < 400) begin
            chk($sformatf("valid_b%0d", idx), tx_valid, 1'b1);
            chk($sformatf("data_b%0d", idx), tx_data, exp_byte(idx, q, sa));
            chk($sformatf("sof_b%0d", idx), tx_sof, idx == 0);
            chk($sformatf("eof_b%0d", idx), tx_eof, idx == FLEN - 1);
            chk($sformatf("busy_b%0d", idx), busy, 1'b1);
            chk($sformatf("ack_b%0d", idx), pause_ack, 1'b0);
            if (chg && idx == 5) pause_quanta = new_q;
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            en = 1'b1;
            if (stall && idx == 10 && stall_cnt < 5) begin
                en = 1'b0;
                stall_cnt++;
            end
            tx_ready = rdy;
            clk_en = en;
            step();
            if (rdy && en) idx++;
            cyc++;
        end
        chk("frame_len", idx, FLEN);
        clk_en = 1'b1;
        tx_ready = 1'b1;
        chk("done_ack", pause_ack, 1'b1);
        chk("done_valid", tx_valid, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_eof", tx_eof, 1'b0);
        if (stall) begin
            clk_en = 1'b0;
            repeat (3) begin
                step();
                chk("done_hold_ack", pause_ack, 1'b1);
                chk("done_hold_busy", busy, 1'b1);
                chk("done_hold_valid", tx_valid, 1'b0);
            end
            clk_en = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        #3 rstn = 1'b0;
        step();
        step();
        chk_idle("reset");
        #2 rstn = 1'b1;
        step();
        chk_idle("idle_no_req");

        // PAUSE with quanta FFFF, full-rate acceptance
        mac_sa       = 48'h00_11_22_33_44_55;
        pause_quanta = 16'hFFFF;
        tx_ready     = 1'b1;
        pause_req    = 1'b1;
        step();
        chk("lat1_valid", tx_valid, 1'b1);
        chk("lat1_sof", tx_sof, 1'b1);
        chk("lat1_data", tx_data, 8'h01);
        pause_req = 1'b0;
        check_frame(16'hFFFF, 48'h00_11_22_33_44_55, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        chk_idle("t1_after");

        // XON with tx_ready toggling
        pause_quanta = 16'h0000;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        check_frame(16'h0000, 48'h00_11_22_33_44_55, 1'b1, 1'b0, 16'h0, 1'b0);
        step();
        chk_idle("t2_after");

        // Quanta changes mid-frame; held request gives a second frame
        pause_quanta = 16'hABCD;
        pause_req    = 1'b1;
        step();
        check_frame(16'hABCD, 48'h00_11_22_33_44_55, 1'b0, 1'b1, 16'h1234, 1'b0);
        step();
        chk("b2b_idle_valid", tx_valid, 1'b0);
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_ack", pause_ack, 1'b0);
        step();
        chk("b2b_start_valid", tx_valid, 1'b1);
        chk("b2b_start_sof", tx_sof, 1'b1);
        pause_req = 1'b0;
        check_frame(16'h1234, 48'h00_11_22_33_44_55, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        chk_idle("t3_after");

        // clk_en stalls at byte 10 and during DONE, new source address
        mac_sa       = 48'hDE_AD_BE_EF_01_02;
        pause_quanta = 16'h0102;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        check_frame(16'h0102, 48'hDE_AD_BE_EF_01_02, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        chk_idle("t4_after");

        // Reset at byte 30 aborts the frame
        pause_quanta = 16'h5555;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("abort_data_b%0d", i), tx_data, exp_byte(i, 16'h5555, 48'hDE_AD_BE_EF_01_02));
            step();
        end
        chk("abort_pre_valid", tx_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk_idle("abort_async");
        step();
        chk("abort_held_ack", pause_ack, 1'b0);
        chk("abort_held_valid", tx_valid, 1'b0);
        pause_req = 1'b1;
        #2 rstn = 1'b1;
        step();
        pause_req = 1'b0;
        check_frame(16'h5555, 48'hDE_AD_BE_EF_01_02, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        chk_idle("t5_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
